// File: rtl/dft_sweep_ctrl.sv
// Sweeps a single-bin DFT engine over all SAMPLES bins and buffers the results.
// Optional per-bin RUN timeout is compiled in with DFT_SWEEP_TIMEOUT_EN.
module dft_sweep_ctrl #(
  parameter int WIDTH   = 24,
  parameter int SAMPLES = 4,
  parameter int IDXW    = $clog2(SAMPLES),
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             eng_reset,
  output logic [IDXW-1:0]  eng_idx,
  input  logic             eng_ready,
  input  logic [WIDTH-1:0] eng_real,
  input  logic [WIDTH-1:0] eng_imag,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_real,
  output logic [WIDTH-1:0] rd_imag
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, CAPT, DONE} state_t;

  state_t           state;
  logic             first_run;
  logic             capture;
  logic             timeout_hit;
  logic             wr_en;
  logic [WIDTH-1:0] wr_real;
  logic [WIDTH-1:0] wr_imag;
  logic [WIDTH-1:0] buf_real [SAMPLES];
  logic [WIDTH-1:0] buf_imag [SAMPLES];

`ifdef DFT_SWEEP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] run_cnt;

  always_comb begin
    timeout_hit = (state == RUN) && (run_cnt == CW'(TIMEOUT)) && !capture;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (state == RUN) begin
      run_cnt <= run_cnt + CW'(1);
    end else begin
      run_cnt <= CW'(1);
    end
  end
`else
  // No timeout in this build: RUN waits for the engine indefinitely.
  always_comb begin
    timeout_hit = (TIMEOUT < 0);
  end
`endif

  // Ready in the first RUN cycle is left over from the previous bin.
  always_comb begin
    capture = (state == RUN) && !first_run && eng_ready;
    wr_en   = capture || timeout_hit;
    wr_real = capture ? eng_real : {WIDTH{1'b0}};
    wr_imag = capture ? eng_imag : {WIDTH{1'b0}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      eng_reset <= 1'b1;
      eng_idx   <= '0;
      first_run <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          eng_reset <= 1'b1;
          if (start) begin
            state   <= ARM;
            eng_idx <= '0;
            busy    <= 1'b1;
            err     <= 1'b0;
          end
        end
        ARM: begin
          state     <= RUN;
          eng_reset <= 1'b0;
          first_run <= 1'b1;
        end
        RUN: begin
          first_run <= 1'b0;
          if (wr_en) begin
            state     <= CAPT;
            eng_reset <= 1'b1;
            if (timeout_hit) begin
              err <= 1'b1;
            end
          end
        end
        CAPT: begin
          if (eng_idx == IDXW'(SAMPLES - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            // CAPT already held the engine in reset, so it serves as the next arm cycle.
            eng_idx   <= eng_idx + IDXW'(1);
            state     <= RUN;
            eng_reset <= 1'b0;
            first_run <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          eng_reset <= 1'b1;
        end
      endcase
    end
  end

  // Result buffer keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      buf_real[eng_idx] <= wr_real;
      buf_imag[eng_idx] <= wr_imag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_real <= '0;
      rd_imag <= '0;
    end else begin
      rd_real <= buf_real[rd_idx];
      rd_imag <= buf_imag[rd_idx];
    end
  end

endmodule

// File: tb/tb_dft_sweep_ctrl.sv
// Directed bench for dft_sweep_ctrl with a behavioural engine model.
// Define DFT_SWEEP_TIMEOUT_EN for both RTL and bench to include the timeout scenario.
module tb_dft_sweep_ctrl;

  localparam int WIDTH   = 24;
  localparam int SAMPLES = 4;
  localparam int IDXW    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             done;
  logic             err;
  logic             eng_reset;
  logic [IDXW-1:0]  eng_idx;
  logic             eng_ready;
  logic [WIDTH-1:0] eng_real;
  logic [WIDTH-1:0] eng_imag;
  logic [IDXW-1:0]  rd_idx;
  logic [WIDTH-1:0] rd_real;
  logic [WIDTH-1:0] rd_imag;

  int n_tests = 0;
  int n_fail  = 0;

  // engine model controls: 0 linear data, 1 idft table, 2 ready stuck high, 3 silent on bin 1
  int eng_mode = 0;
  int eng_lat  = 3;
  int ecnt     = 0;

  logic [WIDTH-1:0] lin_real [SAMPLES] = '{24'h000000, 24'h000100, 24'h000200, 24'h000300};
  logic [WIDTH-1:0] lin_imag [SAMPLES] = '{24'h000000, 24'hffff00, 24'hfffe00, 24'hfffd00};
  logic [WIDTH-1:0] tbl_real [SAMPLES] = '{24'h000500, 24'h000002, 24'h000301, 24'h000002};
  logic [WIDTH-1:0] tbl_imag [SAMPLES] = '{24'h000000, 24'hffff01, 24'h000000, 24'h000100};

  logic log_en = 1'b0;
  logic prev_eng_reset = 1'b1;
  int   done_cnt = 0;
  int   idx_log[$];

  dft_sweep_ctrl #(.WIDTH(WIDTH), .SAMPLES(SAMPLES), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .eng_reset(eng_reset), .eng_idx(eng_idx), .eng_ready(eng_ready),
    .eng_real(eng_real), .eng_imag(eng_imag),
    .rd_idx(rd_idx), .rd_real(rd_real), .rd_imag(rd_imag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (eng_reset) ecnt <= 0;
    else           ecnt <= ecnt + 1;
  end

  always_comb begin
    if (eng_mode == 2)                       eng_ready = 1'b1;
    else if (eng_mode == 3 && eng_idx == 2'd1) eng_ready = 1'b0;
    else                                     eng_ready = !eng_reset && (ecnt >= eng_lat - 1);
    if (eng_mode == 1) begin
      eng_real = tbl_real[eng_idx];
      eng_imag = tbl_imag[eng_idx];
    end else begin
      eng_real = lin_real[eng_idx];
      eng_imag = lin_imag[eng_idx];
    end
  end

  always @(negedge clk) begin
    if (log_en && prev_eng_reset && !eng_reset) idx_log.push_back(int'(eng_idx));
    if (log_en && done) done_cnt++;
    prev_eng_reset <= eng_reset;
  end

  task automatic run_to_done(output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; rd_idx = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, err, eng_reset, eng_idx} !== {1'b0, 1'b0, 1'b0, 1'b1, 2'd0} ||
        rd_real !== 24'h0 || rd_imag !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b err=%b eng_reset=%b idx=%0d rd=%h/%h, want 0 0 0 1 0 0/0",
               busy, done, err, eng_reset, eng_idx, rd_real, rd_imag);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int cyc;
    eng_mode = 0; eng_lat = 3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_busy_after_start: busy=%b want 1", busy);
    end
    cyc = 1;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc !== 18) begin
      n_fail++;
      $display("FAIL sweep_latency: done after %0d cycles want 18", cyc);
    end
    n_tests++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_busy_in_done: busy=%b err=%b want 1 0", busy, err);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL sweep_exit: busy=%b done=%b want 0 0", busy, done);
    end
    for (int i = 0; i < SAMPLES; i++) begin
      rd_idx = IDXW'(i);
      @(negedge clk);
      n_tests++;
      if (rd_real !== lin_real[i] || rd_imag !== lin_imag[i]) begin
        n_fail++;
        $display("FAIL sweep_buf[%0d]: got %h/%h want %h/%h", i, rd_real, rd_imag, lin_real[i], lin_imag[i]);
      end
    end
  endtask

  task automatic test_idft_values();
    int cyc;
    eng_mode = 1; eng_lat = 3;
    run_to_done(cyc);
    n_tests++;
    if (cyc !== 18) begin
      n_fail++;
      $display("FAIL idft_latency: done after %0d cycles want 18", cyc);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < SAMPLES; i++) begin
      rd_idx = IDXW'(i);
      @(negedge clk);
      n_tests++;
      if (rd_real !== tbl_real[i] || rd_imag !== tbl_imag[i]) begin
        n_fail++;
        $display("FAIL idft_buf[%0d]: got %h/%h want %h/%h", i, rd_real, rd_imag, tbl_real[i], tbl_imag[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    eng_mode = 0; eng_lat = 3;
    idx_log.delete();
    done_cnt = 0;
    log_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin
      if (cyc == 6) start = 1'b1;
      else          start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc !== 18) begin
      n_fail++;
      $display("FAIL b2b_latency: done after %0d cycles want 18", cyc);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || eng_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_start_in_done: busy=%b done=%b eng_reset=%b want 0 0 1", busy, done, eng_reset);
    end
    repeat (6) @(negedge clk);
    log_en = 1'b0;
    n_tests++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_count: done pulses=%0d busy=%b want 1 0", done_cnt, busy);
    end
    n_tests++;
    if (idx_log.size() !== 4 || idx_log[0] !== 0 || idx_log[1] !== 1 || idx_log[2] !== 2 || idx_log[3] !== 3) begin
      n_fail++;
      $display("FAIL b2b_idx_seq: %0d bins logged, want 0,1,2,3", idx_log.size());
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc;
    int w;
    eng_mode = 0; eng_lat = 3;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(eng_idx == 2'd2 && !eng_reset) && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (w >= 100) begin
      n_fail++;
      $display("FAIL midrst_reach_bin2: timed out after %0d cycles", w);
    end
    log_en = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || eng_reset !== 1'b1 || done !== 1'b0 || eng_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_state: busy=%b eng_reset=%b done=%b idx=%0d want 0 1 0 0", busy, eng_reset, done, eng_idx);
    end
    repeat (20) @(negedge clk);
    log_en = 1'b0;
    n_tests++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_done: done pulses=%0d busy=%b want 0 0", done_cnt, busy);
    end
    run_to_done(cyc);
    n_tests++;
    if (cyc !== 18) begin
      n_fail++;
      $display("FAIL midrst_restart: done after %0d cycles want 18", cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ready_stuck();
    int cyc;
    eng_mode = 2;
    run_to_done(cyc);
    n_tests++;
    if (cyc !== 14) begin
      n_fail++;
      $display("FAIL stuck_latency: done after %0d cycles want 14", cyc);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < SAMPLES; i++) begin
      rd_idx = IDXW'(i);
      @(negedge clk);
      n_tests++;
      if (rd_real !== lin_real[i] || rd_imag !== lin_imag[i]) begin
        n_fail++;
        $display("FAIL stuck_buf[%0d]: got %h/%h want %h/%h", i, rd_real, rd_imag, lin_real[i], lin_imag[i]);
      end
    end
    eng_mode = 0;
  endtask

`ifdef DFT_SWEEP_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    eng_mode = 3; eng_lat = 3;
    run_to_done(cyc);
    n_tests++;
    if (done !== 1'b1 || err !== 1'b1 || cyc !== 23) begin
      n_fail++;
      $display("FAIL tmo_done: done=%b err=%b after %0d cycles want 1 1 23", done, err, cyc);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < SAMPLES; i++) begin
      rd_idx = IDXW'(i);
      @(negedge clk);
      n_tests++;
      if (rd_real !== ((i == 1) ? 24'h0 : lin_real[i]) || rd_imag !== ((i == 1) ? 24'h0 : lin_imag[i])) begin
        n_fail++;
        $display("FAIL tmo_buf[%0d]: got %h/%h", i, rd_real, rd_imag);
      end
    end
    eng_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_err_clear: err=%b busy=%b want 0 1", err, busy);
    end
    repeat (25) @(negedge clk);
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; rd_idx = '0;
    test_reset();
    test_sweep();
    test_idft_values();
    test_back_to_back();
    test_reset_mid_sweep();
    test_ready_stuck();
`ifdef DFT_SWEEP_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
